lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Takes the ALU result as the effective address and rs2 data as store data, and runs one memory transaction on a req/gnt/rvalid data bus.
- Aligns and sign/zero-extends load data and hands it to writeback.
- Stalls upstream while a transaction is outstanding.

Parameters:
- AW, 32, address width (effective address from ALU result).
- DW, 32, data width. Fixed at 32; byte lanes = DW/8 = 4.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_valid  input  1  EX presents a load/store this cycle
- mem_ready  output  1  LSU can accept (state IDLE)
- mem_we  input  1  1=store, 0=load
- mem_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_sign  input  1  1=sign-extend load, 0=zero-extend
- mem_addr  input  AW  effective address (ALU result)
- mem_wdata  input  DW  store data (rs2)
- mem_rd  input  5  load destination register
- bus_req  output  1  transaction request
- bus_gnt  input  1  request accepted
- bus_addr  output  AW  word-aligned address ({mem_addr[AW-1:2],2'b00})
- bus_we  output  1  write enable
- bus_be  output  4  byte enables
- bus_wdata  output  DW  lane-replicated store data
- bus_rvalid  input  1  read data valid
- bus_rdata  input  DW  read data
- wb_valid  output  1  one-cycle pulse, load result valid
- wb_rd  output  5  load destination register
- wb_data  output  DW  aligned, extended load data
- stall  output  1  high whenever state != IDLE
- misalign_err  output  1  one-cycle misalignment pulse (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): state=IDLE; bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, misalign_err=0. Reset mid-transaction aborts immediately: bus_req drops in the same instant and the pending response is discarded.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: mem_ready=1. On mem_valid, capture addr/we/size/sign/rd/be/wdata into registers and go to REQ.
  - REQ: bus_req=1 with registered bus_* held stable until bus_gnt.
    - gnt & store: go to IDLE.
    - gnt & load: go to WAIT.
  - WAIT: bus_req=0. On bus_rvalid, register the extended data into wb_data, set wb_rd, pulse wb_valid next cycle, and go to IDLE.
- bus_rvalid is ignored outside WAIT. The bus never asserts rvalid in the gnt cycle.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word/reserved: 4'b1111
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- Load data: shifted = bus_rdata >> (8*addr[1:0]); half uses addr[1] only. Then:
  - byte: shifted[7:0] extended
  - half: shifted[15:0] extended
  - word: as is
  - Extension is with the sign bit if mem_sign, else zero.
- Latency, no wait states:
  - load: accept T0, req T1, gnt T1, rvalid T2, wb_valid T3
  - store: accept T0, req/gnt T1, IDLE T2
- wb_valid and a new accept may coincide, since state is IDLE during the wb_valid cycle.
- stall = (state != IDLE). mem_ready = (state == IDLE). EX holds its operands while stall=1.
- Held gnt low: the LSU waits indefinitely in REQ with bus outputs unchanged.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is accepted in IDLE but issues no bus transaction. misalign_err pulses 1 in the next cycle, wb_valid stays 0, and state stays IDLE.
- Not defined: misalign_err is tied 0. Misaligned accesses proceed with the ignored low address bits (half uses addr[1], word uses no low bits), i.e. they are silently aligned down.

Test Plan:
- Reset mid-WAIT (load outstanding, rst_n low) -> bus_req=0, stall=0, and no wb_valid after the late rvalid.
- Store byte, addr=0x1003, wdata=0x000000AB, gnt in first REQ cycle -> bus_addr=0x1000, be=4'b1000, wdata=0xABABABAB, bus_req for exactly 1 cycle, stall high for 1 cycle.
- Load byte signed, addr=0x2001, rdata=0x12348056 -> wb_data=0x00000080 unsigned, 0xFFFFFF80 when mem_sign=1, wb_rd=mem_rd, wb_valid at T3.
- Load half unsigned, addr=0x2002, rdata=0xBEEF1234, gnt delayed 3 cycles -> bus outputs stable for 3 cycles, then wb_data=0x0000BEEF.
- Back-to-back: new load presented in the wb_valid cycle -> accepted that cycle (mem_ready=1), bus_req next cycle.
- With LSU_MISALIGN_TRAP_EN, word load at addr=0x3002 -> no bus_req, misalign_err=1 for one cycle, wb_valid=0. Without the macro -> bus_addr=0x3000, be=4'b1111.

Source files
------------

// File: rtl/lsu_if.sv
// Data-bus bundle between the load/store unit and memory.
// Master drives request/address/data, slave answers with gnt/rvalid/rdata.
interface lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          bus_req;
  logic          bus_gnt;
  logic [AW-1:0] bus_addr;
  logic          bus_we;
  logic [3:0]    bus_be;
  logic [DW-1:0] bus_wdata;
  logic          bus_rvalid;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid transaction per EX op, aligned loads.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic          mem_we,
  input  logic [1:0]    mem_size,
  input  logic          mem_sign,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [4:0]    mem_rd,
  lsu_if.master         bus,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          stall,
  output logic          misalign_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state;

  logic [1:0]    addr_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic [4:0]    rd_q;

  logic [3:0]    be_n;
  logic [DW-1:0] wdata_n;
  logic [1:0]    off;
  logic [DW-1:0] shifted;
  logic [DW-1:0] ld_data;

  assign mem_ready = (state == IDLE);
  assign stall     = (state != IDLE);

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = mem_wdata;
    unique case (mem_size)
      2'b00: begin
        be_n    = 4'b0001 << mem_addr[1:0];
        wdata_n = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << {mem_addr[1], 1'b0};
        wdata_n = {2{mem_wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = mem_wdata;
      end
    endcase
  end

  // Half ignores addr[0], word ignores both low bits.
  always_comb begin
    off     = 2'b00;
    ld_data = '0;
    unique case (size_q)
      2'b00:   off = addr_q;
      2'b01:   off = {addr_q[1], 1'b0};
      default: off = 2'b00;
    endcase
    shifted = bus.bus_rdata >> {off, 3'b000};
    unique case (size_q)
      2'b00:   ld_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_n;
  assign mis_n = ((mem_size == 2'b01) & mem_addr[0])
               | (mem_size[1] & (|mem_addr[1:0]));
`else
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_be    <= 4'b0000;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      addr_q        <= 2'b00;
      size_q        <= 2'b00;
      sign_q        <= 1'b0;
      rd_q          <= 5'd0;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err  <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (mem_valid && mis_n) misalign_err <= 1'b1;
          else
`endif
          if (mem_valid) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= mem_we;
            bus.bus_be    <= be_n;
            bus.bus_addr  <= {mem_addr[AW-1:2], 2'b00};
            bus.bus_wdata <= wdata_n;
            addr_q        <= mem_addr[1:0];
            size_q        <= mem_size;
            sign_q        <= mem_sign;
            rd_q          <= mem_rd;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_gnt) begin
            bus.bus_req <= 1'b0;
            state       <= bus.bus_we ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (bus.bus_rvalid) begin
            wb_valid <= 1'b1;
            wb_data  <= ld_data;
            wb_rd    <= rd_q;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_sign = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [4:0]  mem_rd = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        misalign_err;

  int total = 0;
  int bad = 0;

  lsu_if bus ();

  lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_sign     (mem_sign),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd),
    .bus          (bus),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic present(input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
    mem_valid = 1'b1;
    mem_we    = we;
    mem_size  = sz;
    mem_sign  = sg;
    mem_addr  = a;
    mem_wdata = wd;
    mem_rd    = rd;
  endtask

  task automatic test_reset;
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.bus_req, bus.bus_we, bus.bus_be} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0",
               {bus.bus_req, bus.bus_we, bus.bus_be});
    end
    total++;
    if ({bus.bus_addr, bus.bus_wdata, wb_data} !== 96'd0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0",
               {bus.bus_addr, bus.bus_wdata, wb_data});
    end
    total++;
    if ({wb_valid, wb_rd, misalign_err, stall, mem_ready} !== 9'b000000001) begin
      bad++;
      $display("FAIL reset_state got=%b want=000000001",
               {wb_valid, wb_rd, misalign_err, stall, mem_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_byte;
    present(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00AB, 5'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    total++;
    if (bus.bus_req !== 1'b1 || stall !== 1'b1 || bus.bus_we !== 1'b1) begin
      bad++;
      $display("FAIL stb_req got req=%b stall=%b we=%b want 1 1 1",
               bus.bus_req, stall, bus.bus_we);
    end
    total++;
    if (bus.bus_addr !== 32'h1000 || bus.bus_be !== 4'b1000) begin
      bad++;
      $display("FAIL stb_addr got=%h be=%b want=00001000 1000",
               bus.bus_addr, bus.bus_be);
    end
    total++;
    if (bus.bus_wdata !== 32'hABAB_ABAB) begin
      bad++;
      $display("FAIL stb_wdata got=%h want=abababab", bus.bus_wdata);
    end
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt = 1'b0;
    total++;
    if (bus.bus_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL stb_done got req=%b stall=%b wbv=%b want 0 0 0",
               bus.bus_req, stall, wb_valid);
    end
    present(1'b1, 2'b01, 1'b0, 32'h1002, 32'h1234_BEEF, 5'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    total++;
    if (bus.bus_be !== 4'b1100 || bus.bus_wdata !== 32'hBEEF_BEEF) begin
      bad++;
      $display("FAIL sth got be=%b wdata=%h want 1100 beefbeef",
               bus.bus_be, bus.bus_wdata);
    end
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt = 1'b0;
  endtask

  task automatic test_load_byte(input logic sg, input logic [31:0] exp);
    present(1'b0, 2'b00, sg, 32'h2001, 32'h0, 5'd7);
    @(negedge clk);
    mem_valid = 1'b0;
    total++;
    if (bus.bus_req !== 1'b1 || bus.bus_be !== 4'b0010 ||
        bus.bus_addr !== 32'h2000) begin
      bad++;
      $display("FAIL lb_req got req=%b be=%b addr=%h want 1 0010 00002000",
               bus.bus_req, bus.bus_be, bus.bus_addr);
    end
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt = 1'b0;
    total++;
    if (bus.bus_req !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL lb_wait got req=%b stall=%b wbv=%b want 0 1 0",
               bus.bus_req, stall, wb_valid);
    end
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'h1234_8056;
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== exp) begin
      bad++;
      $display("FAIL lb_wb sign=%b got v=%b rd=%0d data=%h want 1 7 %h",
               sg, wb_valid, wb_rd, wb_data, exp);
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL lb_pulse got wbv=%b want 0", wb_valid);
    end
  endtask

  task automatic test_load_half_wait;
    present(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 5'd9);
    @(negedge clk);
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h2000 ||
          bus.bus_be !== 4'b1100 || bus.bus_we !== 1'b0 || stall !== 1'b1) begin
        bad++;
        $display("FAIL lh_hold%0d got req=%b addr=%h be=%b we=%b stall=%b",
                 i, bus.bus_req, bus.bus_addr, bus.bus_be, bus.bus_we, stall);
      end
      @(negedge clk);
    end
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'hBEEF_1234;
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_BEEF || wb_rd !== 5'd9) begin
      bad++;
      $display("FAIL lh_wb got v=%b data=%h rd=%0d want 1 0000beef 9",
               wb_valid, wb_data, wb_rd);
    end
  endtask

  task automatic test_back_to_back;
    present(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 5'd3);
    @(negedge clk);
    mem_valid   = 1'b0;
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE_F00D || mem_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_wb got v=%b data=%h rdy=%b want 1 cafef00d 1",
               wb_valid, wb_data, mem_ready);
    end
    present(1'b0, 2'b00, 1'b1, 32'h4005, 32'h0, 5'd4);
    @(negedge clk);
    mem_valid = 1'b0;
    total++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h4004 ||
        bus.bus_be !== 4'b0010 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_req got req=%b addr=%h be=%b wbv=%b want 1 00004004 0010 0",
               bus.bus_req, bus.bus_addr, bus.bus_be, wb_valid);
    end
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'h0000_AB00;
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FFAB || wb_rd !== 5'd4) begin
      bad++;
      $display("FAIL b2b_wb2 got v=%b data=%h rd=%0d want 1 ffffffab 4",
               wb_valid, wb_data, wb_rd);
    end
  endtask

  task automatic test_misalign;
    present(1'b0, 2'b10, 1'b0, 32'h3002, 32'h0, 5'd5);
    @(negedge clk);
    mem_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if (bus.bus_req !== 1'b0 || misalign_err !== 1'b1 ||
        wb_valid !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL mis_trap got req=%b err=%b wbv=%b stall=%b want 0 1 0 0",
               bus.bus_req, misalign_err, wb_valid, stall);
    end
    @(negedge clk);
    total++;
    if (misalign_err !== 1'b0 || bus.bus_req !== 1'b0) begin
      bad++;
      $display("FAIL mis_pulse got err=%b req=%b want 0 0",
               misalign_err, bus.bus_req);
    end
`else
    total++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h3000 ||
        bus.bus_be !== 4'b1111 || misalign_err !== 1'b0) begin
      bad++;
      $display("FAIL mis_align got req=%b addr=%h be=%b err=%b want 1 00003000 1111 0",
               bus.bus_req, bus.bus_addr, bus.bus_be, misalign_err);
    end
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'h1122_3344;
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h1122_3344) begin
      bad++;
      $display("FAIL mis_wb got v=%b data=%h want 1 11223344",
               wb_valid, wb_data);
    end
`endif
  endtask

  task automatic test_reset_mid;
    present(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 5'd6);
    @(negedge clk);
    mem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.bus_req !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_req got req=%b stall=%b want 0 0", bus.bus_req, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    present(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 5'd6);
    @(negedge clk);
    mem_valid   = 1'b0;
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt = 1'b0;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_inwait got stall=%b want 1", stall);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.bus_req !== 1'b0 || stall !== 1'b0 || mem_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_wait got req=%b stall=%b rdy=%b want 0 0 1",
               bus.bus_req, stall, mem_ready);
    end
    @(negedge clk);
    rst_n          = 1'b1;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_late got wbv=%b data=%h stall=%b want 0 0 0",
               wb_valid, wb_data, stall);
    end
  endtask

  initial begin
    test_reset;
    test_store_byte;
    test_load_byte(1'b0, 32'h0000_0080);
    test_load_byte(1'b1, 32'hFFFF_FF80);
    test_load_half_wait;
    test_back_to_back;
    test_misalign;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
